seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed hex word and scans the digits one at a time. Each digit gets a dwell period, preceded by an anti-ghosting blank gap. It is the sequential successor to the single-digit hex-to-segment decoder and sits between the datapath and the board display pins.

---
 rtl/seven_seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with a blank gap before each digit.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              led,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {ST_BLANK, ST_ON} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    restart_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              led_q, led_d;
  logic                    frame_start_q;
  logic                    boundary;
  logic [3:0]              nibble;
  logic [4*NUM_DIGITS-1:0] upper;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b1110010;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // The first edge after reset release re-enters digit 0's first phase so the frame
  // (and its frame_start pulse) is aligned to release rather than to the reset edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    if (restart_q) begin
      state_d  = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
      idx_d    = '0;
      cnt_d    = '0;
      boundary = 1'b1;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    end else if (cnt_q == DWELL_LAST) begin
      state_d  = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
      idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      cnt_d    = '0;
      boundary = (idx_d == '0);
    end
  end

  // load is a single-cycle strobe with no back-pressure: captured data always lands in
  // pending; a load on the frame-boundary edge survives the clear and waits one frame.
  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (pend_vld_q) shadow_d = pend_q;
      pend_vld_d = 1'b0;
    end
    if (load) begin
      pend_d     = data;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    an_d   = '1;
    led_d  = 7'b1111111;
    nibble = shadow_d[{idx_d, 2'b00} +: 4];
    upper  = shadow_d >> {idx_d, 2'b00};
    if (state_d == ST_ON && digit_en[idx_d]) begin
      an_d[idx_d] = 1'b0;
      led_d       = seg7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_d != '0 && upper == '0) led_d = 7'b1111111;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      restart_q     <= 1'b1;
      an_q          <= '1;
      led_q         <= 7'b1111111;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      restart_q     <= 1'b0;
      an_q          <= an_d;
      led_q         <= led_d;
      frame_start_q <= boundary;
    end
  end

  assign an          = an_q;
  assign led         = led_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, dwell 4, blank 2 (24-cycle frame).
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SLOT = DW + BL;
  localparam int FR = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  an;
  logic [6:0]  led;
  logic        frame_start;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .load(load), .digit_en(digit_en),
    .an(an), .led(led), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: seg_ref = 7'b0000001;  4'h1: seg_ref = 7'b1001111;
      4'h2: seg_ref = 7'b0010010;  4'h3: seg_ref = 7'b0000110;
      4'h4: seg_ref = 7'b1001100;  4'h5: seg_ref = 7'b0100100;
      4'h6: seg_ref = 7'b0100000;  4'h7: seg_ref = 7'b0001111;
      4'h8: seg_ref = 7'b0000000;  4'h9: seg_ref = 7'b0000100;
      4'hA: seg_ref = 7'b0001000;  4'hB: seg_ref = 7'b1100000;
      4'hC: seg_ref = 7'b1110010;  4'hD: seg_ref = 7'b1000010;
      4'hE: seg_ref = 7'b0110000;  default: seg_ref = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge of frame cycle 0; checks cycles 0..stop_at-1 and optionally
  // pulses load at cycles la1/la2. digit_en is switched during cycle 0 (a blank cycle).
  task automatic run_frame(input logic [15:0] word, input logic [3:0] en, input int stop_at,
                           input int la1, input logic [15:0] w1,
                           input int la2, input logic [15:0] w2, input string tag);
    for (int i = 0; i < stop_at; i++) begin
      int         slot;
      int         pos;
      logic [3:0] exp_an;
      logic [6:0] exp_led;
      slot    = i / SLOT;
      pos     = i % SLOT;
      exp_an  = 4'hF;
      exp_led = 7'b1111111;
      if (pos >= BL && en[slot]) begin
        exp_an[slot] = 1'b0;
        exp_led      = seg_ref(word[slot*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (word >> (4 * slot)) == 16'h0) exp_led = 7'b1111111;
`endif
      end
      chk($sformatf("%s c%0d frame_start", tag, i), 16'(frame_start), 16'(i == 0));
      chk($sformatf("%s c%0d an", tag, i), 16'(an), 16'(exp_an));
      chk($sformatf("%s c%0d led", tag, i), 16'(led), 16'(exp_led));
      if (i == 0) digit_en = en;
      if (i == la1) begin
        load = 1'b1;
        data = w1;
      end else if (i == la2) begin
        load = 1'b1;
        data = w2;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset an", 16'(an), 16'hF);
    chk("reset led", 16'(led), 16'h7F);
    chk("reset frame_start", 16'(frame_start), 16'h0);

    reset = 1'b1;
    tick();
    run_frame(16'h0000, 4'hF, FR, 3, 16'h1234, -1, 16'h0, "init");
    run_frame(16'h1234, 4'hF, FR, 5, 16'h9870, -1, 16'h0, "t1234");
    for (int k = 0; k < 16; k++) begin
      logic [15:0] nxt;
      nxt = (k < 15) ? {12'h987, 4'(k + 1)} : 16'hABCD;
      run_frame({12'h987, 4'(k)}, 4'hF, FR, 5, nxt, -1, 16'h0, $sformatf("sweep%0d", k));
    end
    run_frame(16'hABCD, 4'b1010, FR, 2, 16'h1111, 10, 16'h2222, "en1010");
    run_frame(16'h2222, 4'hF, FR, 7, 16'h3333, FR - 1, 16'h4444, "lastwins");
    run_frame(16'h3333, 4'hF, FR, -1, 16'h0, -1, 16'h0, "boundary_old");
    run_frame(16'h4444, 4'hF, FR, 4, 16'h0050, -1, 16'h0, "boundary_new");
    run_frame(16'h0050, 4'hF, FR, -1, 16'h0, -1, 16'h0, "w0050");
    run_frame(16'h0050, 4'hF, 15, 3, 16'h7777, -1, 16'h0, "pre_reset");

    reset = 1'b0;
    tick();
    chk("midreset an", 16'(an), 16'hF);
    chk("midreset led", 16'(led), 16'h7F);
    chk("midreset frame_start", 16'(frame_start), 16'h0);
    tick();
    chk("midreset hold an", 16'(an), 16'hF);
    chk("midreset hold frame_start", 16'(frame_start), 16'h0);
    reset = 1'b1;
    tick();
    run_frame(16'h0000, 4'hF, FR, -1, 16'h0, -1, 16'h0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
